// File: rtl/prng_ranged_if.sv
// Request/result bundle between the food-placement controller and prng_ranged.
interface prng_ranged_if #(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 6
);
  logic              request_rand;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic              prng_busy;
  logic              prng_done;
  logic [OUT_W-1:0]  random_num;
  logic              fallback;

  modport master (
    output request_rand, seed_load, seed_in,
    input  prng_busy, prng_done, random_num, fallback
  );
  modport slave (
    input  request_rand, seed_load, seed_in,
    output prng_busy, prng_done, random_num, fallback
  );
endinterface

// File: rtl/prng_ranged.sv
// Free-running Galois LFSR with seed reload and rejection sampling into [0, RANGE).
// Results are handed out through a request/done handshake.
module prng_ranged #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                OUT_W     = 6,
  parameter int                RANGE     = 64,
  parameter int                MAX_TRIES = 8
) (
  input  logic          clka,
  input  logic          restart,
  prng_ranged_if.slave  bus
);
  localparam int              TW      = $clog2(MAX_TRIES + 1);
  localparam logic [OUT_W:0]  RANGE_V = (OUT_W + 1)'(RANGE);

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [TW-1:0]     tries;
  logic [OUT_W-1:0]  cand, rnum_q;
  logic              fb_q;
  logic              accept, give_up;

  assign cand    = lfsr[OUT_W-1:0];
  assign accept  = {1'b0, cand} < RANGE_V;
  assign give_up = (tries == TW'(MAX_TRIES - 1));

  // A zero seed would lock the LFSR, so it is swapped for the fallback seed.
  always_ff @(posedge clka) begin
    if (restart)             lfsr <= SEED;
    else if (bus.seed_load)  lfsr <= (bus.seed_in == '0) ? SEED : bus.seed_in;
    else if (lfsr[0])        lfsr <= (lfsr >> 1) ^ TAPS;
    else                     lfsr <= lfsr >> 1;
  end

  always_ff @(posedge clka) begin
    if (restart) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.request_rand) state_nxt = SAMPLE;
      SAMPLE:  if (accept || give_up) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.prng_busy = (state != IDLE);
    bus.prng_done = (state == DONE);
  end

  // Halving a rejected candidate always lands below RANGE since RANGE > 2^(OUT_W-1).
  always_ff @(posedge clka) begin
    if (restart) begin
      tries  <= '0;
      rnum_q <= '0;
      fb_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.request_rand) tries <= '0;
        SAMPLE: begin
          if (accept) begin
            rnum_q <= cand;
            fb_q   <= 1'b0;
          end else if (give_up) begin
            rnum_q <= {1'b0, cand[OUT_W-1:1]};
            fb_q   <= 1'b1;
          end else begin
            tries  <= tries + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.random_num = rnum_q;
  assign bus.fallback   = fb_q;
endmodule

// File: tb/tb_prng_ranged.sv
// Two instances (full range, and RANGE=33 with two tries) share stimulus; each has
// its own transaction-level reference model, result queue and output monitor.
module tb_prng_ranged;
  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic        req = 1'b0;
  logic        sl = 1'b0;
  logic [15:0] sin = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clka = ~clka;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic chk(input int inst, input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL u%0d %s: got %0d, expected %0d (t=%0t)", inst, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int R  = (g == 0) ? 64 : 33;
    localparam int MT = (g == 0) ? 8 : 2;

    prng_ranged_if #(.LFSR_W(16), .OUT_W(6)) bus ();
    assign bus.request_rand = req;
    assign bus.seed_load    = sl;
    assign bus.seed_in      = sin;

    prng_ranged #(.RANGE(R), .MAX_TRIES(MT)) dut (
      .clka    (clka),
      .restart (restart),
      .bus     (bus)
    );

    // Reference: the random stream is a sequence of LFSR values indexed by edge
    // number; a transaction opened at edge k consumes candidates from edges
    // k+1, k+2, ... and the next request is honoured two edges after completion.
    logic [15:0] m_lfsr = 16'hACE1;
    int          n = 0, t_start = 0, free_edge = 0;
    bit          t_open = 1'b0, m_busy = 1'b0;
    int          m_rn = 0;
    bit          m_fb = 1'b0;
    logic [6:0]  expq[$];

    always @(posedge clka) begin
      int c;
      bit pushed;
      n++;
      pushed = 1'b0;
      if (restart) begin
        m_lfsr = 16'hACE1; t_open = 1'b0; free_edge = n + 1;
        m_rn = 0; m_fb = 1'b0;
        expq.delete();
      end else begin
        if (t_open) begin
          c = int'(m_lfsr % 64);
          if (c < R) begin
            m_rn = c; m_fb = 1'b0; pushed = 1'b1;
          end else if (n - t_start == MT) begin
            m_rn = c / 2; m_fb = 1'b1; pushed = 1'b1;
          end
          if (pushed) begin
            expq.push_back({m_fb, 6'(m_rn)});
            t_open = 1'b0; free_edge = n + 2;
          end
        end else if (req && n >= free_edge) begin
          t_open = 1'b1; t_start = n;
        end
        m_lfsr = sl ? ((sin == 16'h0) ? 16'hACE1 : sin) : lfsr_next(m_lfsr);
      end
      m_busy = t_open || pushed;
    end

    int mcyc = 0, last_done = -100;
    always @(negedge clka) begin
      logic [6:0] e;
      mcyc++;
      chk(g, "busy", int'(bus.prng_busy), int'(m_busy));
      chk(g, "random_num hold", int'(bus.random_num), m_rn);
      chk(g, "fallback hold", int'(bus.fallback), int'(m_fb));
      if (bus.prng_done) begin
        if (expq.size() == 0) begin
          chk(g, "unexpected done", 1, 0);
        end else begin
          e = expq.pop_front();
          chk(g, "result value", int'(bus.random_num), int'(e[5:0]));
          chk(g, "result fallback", int'(bus.fallback), int'(e[6]));
        end
        chk(g, "result in range", int'(int'(bus.random_num) < R), 1);
        chk(g, "done spacing>=3", int'(mcyc - last_done >= 3), 1);
        last_done = mcyc;
      end else if (expq.size() != 0) begin
        chk(g, "missing done", 0, 1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(negedge clka);
    restart = 1'b0;
    repeat (4) @(negedge clka);
    chk(0, "idle after reset rn", int'(u[0].bus.random_num), 0);
    chk(1, "idle after reset busy", int'(u[1].bus.prng_busy), 0);

    // single request pulse
    req = 1'b1;
    @(negedge clka); req = 1'b0;
    @(negedge clka);
    chk(0, "full-range latency 2", int'(u[0].bus.prng_done), 1);
    repeat (5) @(negedge clka);

    // seed 0x007F: candidates 63, 63 -> full range takes 63, RANGE=33 falls back to 31
    sl = 1'b1; sin = 16'h007F; req = 1'b1;
    @(negedge clka); sl = 1'b0; req = 1'b0;
    repeat (5) @(negedge clka);
    chk(0, "seed 7F rn", int'(u[0].bus.random_num), 63);
    chk(0, "seed 7F fb", int'(u[0].bus.fallback), 0);
    chk(1, "seed 7F fallback rn", int'(u[1].bus.random_num), 31);
    chk(1, "seed 7F fallback fb", int'(u[1].bus.fallback), 1);

    // seed 0 maps to 0xACE1: candidates 33 (==RANGE, rejected) then 48
    sl = 1'b1; sin = 16'h0000; req = 1'b1;
    @(negedge clka); sl = 1'b0; req = 1'b0;
    repeat (5) @(negedge clka);
    chk(0, "seed 0 rn", int'(u[0].bus.random_num), 33);
    chk(1, "seed 0 fallback rn", int'(u[1].bus.random_num), 24);
    chk(1, "seed 0 fallback fb", int'(u[1].bus.fallback), 1);

    // restart while sampling: no pulse, result cleared
    req = 1'b1;
    @(negedge clka); req = 1'b0; restart = 1'b1;
    @(negedge clka); restart = 1'b0;
    chk(0, "abort clears rn", int'(u[0].bus.random_num), 0);
    chk(1, "abort busy", int'(u[1].bus.prng_busy), 0);
    repeat (3) @(negedge clka);

    // randomized traffic with seed loads and occasional restarts
    for (int i = 0; i < 400; i++) begin
      req     = 1'($urandom_range(0, 1));
      sl      = ($urandom_range(0, 15) == 0);
      sin     = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      restart = ($urandom_range(0, 79) == 0);
      @(negedge clka);
    end
    restart = 1'b0; sl = 1'b0;

    // request held high
    req = 1'b1;
    repeat (300) @(negedge clka);
    req = 1'b0;
    repeat (12) @(negedge clka);

    chk(0, "queue drained", u[0].expq.size(), 0);
    chk(1, "queue drained", u[1].expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
